// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared FSM state type for the APB round-robin arbiter
package apb_arb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;
endpackage

// File: rtl/apb_rr_pick.sv
// apb_rr_pick: combinational round-robin picker, first request at/after ptr with wrap
module apb_rr_pick #(
  parameter int NumMst = 3,
  parameter int IdxW   = $clog2(NumMst)
) (
  input  logic [NumMst-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumMst-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              valid_o
);
  // Scanning from the farthest offset down lets the nearest hit win without a found flag
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int o = NumMst - 1; o >= 0; o--) begin
      if (req_i[(int'(ptr_i) + o) % NumMst]) begin
        idx_o = IdxW'((int'(ptr_i) + o) % NumMst);
        gnt_o = NumMst'(1) << ((int'(ptr_i) + o) % NumMst);
      end
    end
  end
  assign valid_o = |req_i;
endmodule

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: shares one APB completer among NumMst requesters, round-robin per transfer
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NumMst        = 3,
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumMst-1:0]             mst_psel_i,
  input  logic [NumMst-1:0]             mst_penable_i,
  input  logic [NumMst-1:0]             mst_pwrite_i,
  input  logic [NumMst*AddrWidth-1:0]   mst_paddr_i,
  input  logic [NumMst*DataWidth-1:0]   mst_pwdata_i,
  output logic [DataWidth-1:0]          mst_prdata_o,
  output logic [NumMst-1:0]             mst_pready_o,
  output logic [NumMst-1:0]             mst_pslverr_o,
  output logic                          slv_psel_o,
  output logic                          slv_penable_o,
  output logic                          slv_pwrite_o,
  output logic [AddrWidth-1:0]          slv_paddr_o,
  output logic [DataWidth-1:0]          slv_pwdata_o,
  input  logic [DataWidth-1:0]          slv_prdata_i,
  input  logic                          slv_pready_i,
  input  logic                          slv_pslverr_i,
  output logic [NumMst-1:0]             grant_o,
  output logic                          timeout_o
);
  localparam int IdxW = $clog2(NumMst);
  localparam int CntW = TimeoutCycles == 0 ? 1 : $clog2(TimeoutCycles + 1);
  state_e                state_q, state_d;
  logic [IdxW-1:0]       ptr_q, ptr_d, idx_q, idx_d, pick_idx;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [NumMst-1:0]     grant_q, grant_d, pick_gnt;
  logic                  pwrite_q, pwrite_d, pick_valid;
  logic [AddrWidth-1:0]  paddr_q, paddr_d;
  logic [DataWidth-1:0]  pwdata_q, pwdata_d;
  logic                  done, tmo, finish, capture, live, resp;
  apb_rr_pick #(.NumMst(NumMst), .IdxW(IdxW)) u_pick (
    .req_i   (mst_psel_i),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );
  assign done    = state_q == ACCESS && slv_pready_i;
  assign tmo     = state_q == ACCESS && !slv_pready_i && TimeoutCycles != 0 &&
                   cnt_q == CntW'(TimeoutCycles - 1);
  assign finish  = done || tmo;
  assign capture = state_q == IDLE && pick_valid;
  // A requester that abandoned its transfer gets no response; the downstream beat still runs out
  assign live    = mst_psel_i[idx_q] && mst_penable_i[idx_q];
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      grant_q  <= '0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
    end
  end
  always_comb begin
    state_d  = state_q == IDLE  ? (pick_valid ? SETUP : IDLE) :
               state_q == SETUP ? ACCESS : (finish ? IDLE : ACCESS);
    ptr_d    = finish ? (idx_q == IdxW'(NumMst - 1) ? '0 : idx_q + IdxW'(1)) : ptr_q;
    cnt_d    = state_q == ACCESS ? cnt_q + CntW'(1) : '0;
    grant_d  = capture ? pick_gnt : (finish ? '0 : grant_q);
    idx_d    = capture ? pick_idx : idx_q;
    pwrite_d = capture ? mst_pwrite_i[pick_idx] : pwrite_q;
    paddr_d  = capture ? mst_paddr_i[pick_idx*AddrWidth +: AddrWidth] : paddr_q;
    pwdata_d = capture ? mst_pwdata_i[pick_idx*DataWidth +: DataWidth] : pwdata_q;
  end
  always_comb begin
    resp          = finish && live;
    mst_pready_o  = resp ? grant_q : '0;
    mst_pslverr_o = resp && (tmo || slv_pslverr_i) ? grant_q : '0;
    mst_prdata_o  = resp && done ? slv_prdata_i : '0;
    timeout_o     = tmo;
    slv_psel_o    = state_q != IDLE;
    slv_penable_o = state_q == ACCESS;
    slv_pwrite_o  = pwrite_q;
    slv_paddr_o   = paddr_q;
    slv_pwdata_o  = pwdata_q;
    grant_o       = grant_q;
  end
endmodule

// File: tb/tb_apb_rr_arbiter.sv
// tb_apb_rr_arbiter: directed plus randomized transfers checked against a transfer-level model
module tb_apb_rr_arbiter;
  localparam int N = 3, AW = 32, DW = 32, TMO = 8;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [N-1:0] psel = '0, pen = '0, pwr = '0;
  logic [AW-1:0] addr [N];
  logic [DW-1:0] wdata [N];
  logic [N*AW-1:0] paddr_pk;
  logic [N*DW-1:0] pwdata_pk;
  logic [DW-1:0] mst_prdata, slv_paddr_dummy, slv_prdata = '0;
  logic [N-1:0] mst_pready, mst_pslverr, grant;
  logic slv_psel, slv_penable, slv_pwrite, slv_pready = 1'b0, slv_pslverr = 1'b0, timeout;
  logic [AW-1:0] slv_paddr;
  logic [DW-1:0] slv_pwdata;
  int errors = 0, checks = 0, ptr = 0;
  assign paddr_pk  = {addr[2], addr[1], addr[0]};
  assign pwdata_pk = {wdata[2], wdata[1], wdata[0]};
  assign slv_paddr_dummy = '0;

  apb_rr_arbiter #(.NumMst(N), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .mst_psel_i(psel), .mst_penable_i(pen), .mst_pwrite_i(pwr),
    .mst_paddr_i(paddr_pk), .mst_pwdata_i(pwdata_pk),
    .mst_prdata_o(mst_prdata), .mst_pready_o(mst_pready), .mst_pslverr_o(mst_pslverr),
    .slv_psel_o(slv_psel), .slv_penable_o(slv_penable), .slv_pwrite_o(slv_pwrite),
    .slv_paddr_o(slv_paddr), .slv_pwdata_o(slv_pwdata),
    .slv_prdata_i(slv_prdata), .slv_pready_i(slv_pready), .slv_pslverr_i(slv_pslverr),
    .grant_o(grant), .timeout_o(timeout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] req, input int p);
    for (int o = 0; o < N; o++) if (req[(p + o) % N]) return (p + o) % N;
    return 0;
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // One whole transfer from its IDLE request cycle to the completion cycle; returns in the following IDLE cycle
  task automatic xfer(input logic [N-1:0] req, input int waits, input logic err,
                      input logic [DW-1:0] rd, input bit drop, input int exp_g);
    int g;
    logic [N-1:0] gv;
    bit done, tmo;
    psel = req; pen = req; slv_pready = 1'b0;
    g = exp_g >= 0 ? exp_g : pick(req, ptr);
    gv = N'(1) << g;
    @(negedge clk);
    chk("idle_psel", 64'(slv_psel), 0);
    chk("idle_grant", 64'(grant), 0);
    next();
    @(negedge clk);
    chk("setup_psel", 64'(slv_psel), 1);
    chk("setup_penable", 64'(slv_penable), 0);
    chk("setup_grant", 64'(grant), 64'(gv));
    chk("setup_paddr", 64'(slv_paddr), 64'(addr[g]));
    chk("setup_pwdata", 64'(slv_pwdata), 64'(wdata[g]));
    chk("setup_pwrite", 64'(slv_pwrite), 64'(pwr[g]));
    chk("setup_pready", 64'(mst_pready), 0);
    next();
    for (int w = 0; w < 64; w++) begin
      if (drop && w == 0) begin psel[g] = 1'b0; pen[g] = 1'b0; end
      done = (w == waits);
      tmo = !done && (w == TMO - 1);
      slv_pready = done; slv_pslverr = err; slv_prdata = rd;
      @(negedge clk);
      chk("acc_psel", 64'(slv_psel), 1);
      chk("acc_penable", 64'(slv_penable), 1);
      chk("acc_grant", 64'(grant), 64'(gv));
      chk("acc_pready", 64'(mst_pready), ((done || tmo) && !drop) ? 64'(gv) : 0);
      chk("acc_pslverr", 64'(mst_pslverr), (((done && err) || tmo) && !drop) ? 64'(gv) : 0);
      chk("acc_prdata", 64'(mst_prdata), (done && !drop) ? 64'(rd) : 0);
      chk("acc_timeout", 64'(timeout), 64'(tmo));
      if (done || tmo) break;
      next();
    end
    ptr = (g + 1) % N;
    next();
    slv_pready = 1'b0; slv_pslverr = 1'b0; slv_prdata = '0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin addr[i] = 32'h100 * i; wdata[i] = 32'hA0 + i; end
    next(); next();
    rst = 1'b0;
    // reset mid-ACCESS with the completer stalled
    psel = 3'b100; pen = 3'b100; pwr = 3'b100;
    next(); next(); next();
    chk("pre_rst_access", 64'(slv_penable), 1);
    rst = 1'b1;
    #1;
    chk("rst_psel", 64'(slv_psel), 0);
    chk("rst_penable", 64'(slv_penable), 0);
    chk("rst_pwrite", 64'(slv_pwrite), 0);
    chk("rst_paddr", 64'(slv_paddr), 0);
    chk("rst_pwdata", 64'(slv_pwdata), 0);
    chk("rst_grant", 64'(grant), 0);
    chk("rst_pready", 64'(mst_pready), 0);
    chk("rst_pslverr", 64'(mst_pslverr), 0);
    chk("rst_prdata", 64'(mst_prdata), 0);
    chk("rst_timeout", 64'(timeout), 0);
    psel = '0; pen = '0; pwr = '0;
    next();
    rst = 1'b0; ptr = 0;
    // three requesters held continuously, two wait states each
    for (int k = 0; k < 6; k++) xfer(3'b111, 2, 1'b0, 32'h5000 + k, 1'b0, k % 3);
    // requester 0 write, zero-wait completer
    addr[0] = 32'h0000_0004; wdata[0] = 32'hDEAD_BEEF; pwr = 3'b001;
    xfer(3'b001, 0, 1'b0, 32'h0, 1'b0, 0);
    psel = '0; pen = '0;
    @(negedge clk);
    chk("hold_paddr", 64'(slv_paddr), 64'h4);
    chk("hold_pwdata", 64'(slv_pwdata), 64'hDEAD_BEEF);
    next();
    // requester 1 read with error after three waits
    pwr = 3'b000; addr[1] = 32'h0000_0010;
    xfer(3'b010, 3, 1'b1, 32'h1234_5678, 1'b0, 1);
    psel = '0; pen = '0;
    @(negedge clk);
    chk("after_prdata", 64'(mst_prdata), 0);
    chk("after_pready", 64'(mst_pready), 0);
    next();
    // completer never ready: forced termination, then the other pending requester
    xfer(3'b011, 99, 1'b0, 32'hFFFF_FFFF, 1'b0, 0);
    xfer(3'b011, 0, 1'b0, 32'h0000_0BBB, 1'b0, 1);
    // granted requester 2 abandons mid-transfer; pointer still advances to 0
    xfer(3'b100, 1, 1'b0, 32'hCAFE_0000, 1'b1, 2);
    xfer(3'b111, 0, 1'b0, 32'h0000_0C0C, 1'b0, 0);
    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin addr[i] = $urandom; wdata[i] = $urandom; end
      pwr = N'($urandom_range(0, 7));
      xfer(N'($urandom_range(1, 7)), $urandom_range(0, 9) == 0 ? 99 : $urandom_range(0, 4),
           1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 7) == 0, -1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
